// File: rtl/exp4_interface_jogada.sv
// Button input stage for the switch-vs-memory comparison datapath.
// Synchronizes the raw pushbuttons and start button, debounces the button
// vector on both press and release, and hands the control unit a registered
// 4-bit move plus a single-cycle "move done" strobe. A separate path turns the
// start button into a single-cycle start pulse.
module exp4_interface_jogada #(
  parameter int DEBOUNCE_CICLOS = 50000,  // stable cycles required on press and on release
  parameter int CONT_W          = 16      // counter width, 2**CONT_W > DEBOUNCE_CICLOS
) (
  input  logic       clock,
  input  logic       reset,            // asynchronous, active-low
  input  logic [3:0] botoes,
  input  logic       iniciar,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_multipla,
  output logic       iniciar_pulso,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    DEB_APERTA   = 4'd1,
    CAPTURA      = 4'd2,
    ESPERA_SOLTA = 4'd3,
    DEB_SOLTA    = 4'd4
  } estado_t;

  // The counter leaves its state when it reaches this value, so it never wraps.
  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic [3:0]        b_meta, sb;
  logic              i_meta, si, si_prev;

  estado_t           state, state_next;
  logic [CONT_W-1:0] cont, cont_next;
  logic [3:0]        amostra, amostra_next;

  // Two-flop synchronizers for both inputs, plus the start-edge detector.
  // NOTE: clocked state is written with <= so every flop samples the values
  // from before the edge; blocking here would collapse the 2-FF chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_meta        <= '0;
      sb            <= '0;
      i_meta        <= 1'b0;
      si            <= 1'b0;
      si_prev       <= 1'b0;
      iniciar_pulso <= 1'b0;
    end else begin
      b_meta        <= botoes;
      sb            <= b_meta;
      i_meta        <= iniciar;
      si            <= i_meta;
      si_prev       <= si;
      iniciar_pulso <= si & ~si_prev;
    end
  end

  // State, debounce counter and the sampled button vector.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= INICIAL;
      cont    <= '0;
      amostra <= '0;
    end else begin
      state   <= state_next;
      cont    <= cont_next;
      amostra <= amostra_next;
    end
  end

  // Next-state logic: debounce on press, single capture, debounce on release.
  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    cont_next    = cont;
    amostra_next = amostra;
    case (state)
      INICIAL: begin
        if (sb != 4'b0000) begin
          state_next   = DEB_APERTA;
          amostra_next = sb;
          cont_next    = '0;
        end
      end
      DEB_APERTA: begin
        if (sb == 4'b0000) begin
          state_next = INICIAL;
        end else if (sb != amostra) begin
          // Bounce between two nonzero patterns: restart on the new one.
          amostra_next = sb;
          cont_next    = '0;
        end else if (cont == CONT_MAX) begin
          state_next = CAPTURA;
        end else begin
          cont_next = cont + CONT_W'(1);
        end
      end
      CAPTURA: begin
        state_next = ESPERA_SOLTA;
      end
      ESPERA_SOLTA: begin
        // Changes among nonzero patterns while held are ignored.
        if (sb == 4'b0000) begin
          state_next = DEB_SOLTA;
          cont_next  = '0;
        end
      end
      DEB_SOLTA: begin
        if (sb != 4'b0000) begin
          state_next = ESPERA_SOLTA;
        end else if (cont == CONT_MAX) begin
          state_next = INICIAL;
        end else begin
          cont_next = cont + CONT_W'(1);
        end
      end
      default: begin
        state_next = INICIAL;
      end
    endcase
  end

  // Move registers: updated on the edge that enters CAPTURA, so jogada and
  // the strobe become valid together and jogada holds until the next capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogada          <= '0;
      jogada_multipla <= 1'b0;
      jogada_feita    <= 1'b0;
    end else begin
      jogada_feita <= (state_next == CAPTURA);
      if (state_next == CAPTURA) begin
        jogada          <= amostra;
        // More than one bit set iff clearing the lowest set bit leaves any.
        jogada_multipla <= ((amostra & (amostra - 4'd1)) != 4'b0000);
      end
    end
  end

  assign db_estado = state;

endmodule

// File: doc/exp4_interface_jogada.md
Name: exp4_interface_jogada

Overview:
- Upstream input stage for the sequential switch-vs-memory comparison datapath.
- Converts raw pushbuttons into a debounced, registered 4-bit move (jogada) plus a single-cycle "move done" strobe for the control unit.
- Also synchronizes iniciar and produces a single-cycle start pulse.
- db_estado feeds a hexa7seg debug display.

Parameters:
- DEBOUNCE_CICLOS, 50000, number of consecutive stable cycles required on press and on release (1 ms at 50 MHz); minimum 2; the bench uses 4.
- CONT_W, 16, width of the debounce counter; must satisfy 2^CONT_W > DEBOUNCE_CICLOS.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- botoes  in  4  raw, asynchronous, bouncing pushbuttons; active-high.
- iniciar  in  1  raw, asynchronous start button; active-high.
- jogada  out  4  last captured debounced button vector; held until the next capture.
- jogada_feita  out  1  one-cycle strobe: jogada was updated this cycle.
- jogada_multipla  out  1  captured vector has more than one bit set; held with jogada.
- iniciar_pulso  out  1  one-cycle pulse on the synchronized rising edge of iniciar.
- db_estado  out  4  current FSM state code.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both synchronizer stages of botoes and iniciar clear to 0.
  - Counter, amostra register, jogada, jogada_multipla, jogada_feita and iniciar_pulso clear to 0.
  - State goes to INICIAL; db_estado=0.
- Synchronizers: 2-FF chains per bit. sb denotes the synchronized botoes and si the synchronized iniciar.
- iniciar_pulso is registered and equals si AND NOT si_previous. It is high for exactly one cycle, two edges after the first edge that samples iniciar=1. No debounce is applied.
- FSM states and codes: INICIAL=0, DEB_APERTA=1, CAPTURA=2, ESPERA_SOLTA=3, DEB_SOLTA=4. Codes 5-15 are unused; any unused code returns to INICIAL.
- INICIAL:
  - If sb!=0: go to DEB_APERTA, amostra<=sb, counter<=0.
  - Otherwise stay.
- DEB_APERTA:
  - If sb==0: go to INICIAL.
  - Else if sb!=amostra: amostra<=sb, counter<=0, stay (restart debounce).
  - Else if counter==DEBOUNCE_CICLOS-1: go to CAPTURA.
  - Else counter+1.
- CAPTURA (one cycle):
  - jogada<=amostra and jogada_multipla<=(popcount(amostra)>1) take effect on entry.
  - jogada_feita is high only while in CAPTURA.
  - Next state is always ESPERA_SOLTA.
- ESPERA_SOLTA:
  - If sb==0: go to DEB_SOLTA, counter<=0.
  - Changes among nonzero values are ignored; no new capture occurs.
- DEB_SOLTA:
  - If sb!=0: go back to ESPERA_SOLTA.
  - Else if counter==DEBOUNCE_CICLOS-1: go to INICIAL.
  - Else counter+1.
- Press latency: with botoes stable from edge 0, DEB_APERTA is entered at edge 2 and CAPTURA at edge DEBOUNCE_CICLOS+2. jogada and jogada_feita are valid in the cycle after that edge.
- Single-cycle strobe: at most one jogada_feita per press/release cycle, regardless of how long the button is held.
- Bounce during press: any bounce restarts the count. Any glitch to zero in DEB_APERTA aborts with no capture.
- Counter must not wrap. It saturates logically via the state exit at DEBOUNCE_CICLOS-1.
- Simultaneous iniciar and button activity: the two paths are fully independent.
- Buttons held through reset release: treated as a new press and captured after a full debounce.
- Reset mid-debounce or in CAPTURA: no strobe is emitted, and jogada returns to 0.

Test Plan:
- Reset: reset=0 with random inputs → all outputs 0, db_estado=0; outputs stay 0 for 10 cycles after release with botoes=0.
- Clean press (DEBOUNCE_CICLOS=4): botoes=4'b0100 from edge 0, held 20 cycles → jogada_feita high only in the cycle after edge 6; jogada=4'h4, jogada_multipla=0; no further strobe while held; release for 6 cycles → db_estado back to 0.
- Bouncing press: botoes toggles 0100/0000 every 2 cycles for 10 cycles, then stable 0100 → exactly one strobe, 6 edges after stability begins; jogada=4'h4.
- Multi-key: botoes=4'b1010 held → jogada=4'hA, jogada_multipla=1. Next press 4'b0001 → jogada=4'h1, jogada_multipla=0.
- Release glitch: in DEB_SOLTA, botoes=0001 for one cycle → FSM returns to ESPERA_SOLTA with no new strobe; after a full release, a new press 4'b1000 → jogada=4'h8 with exactly one strobe.
- iniciar held high 30 cycles → iniciar_pulso high exactly one cycle (after edge 2). Reset asserted mid DEB_APERTA → no strobe, jogada=0.
